// File: rtl/imm_decode_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : imm_pkg
//  Description : Immediate format codes, opcode constants and the buffered
//                entry record shared by the ID-stage immediate sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I    = 3'b000,
        IMM_S    = 3'b001,
        IMM_B    = 3'b010,
        IMM_J    = 3'b011,
        IMM_U    = 3'b100,
        IMM_NONE = 3'b111
    } imm_type_t;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] imm;
        imm_type_t   imm_type;
        logic        illegal;
    } entry_t;

    localparam entry_t ENTRY_RESET = '{
        pc:       32'h0,
        instr:    32'h0,
        imm:      32'h0,
        imm_type: IMM_NONE,
        illegal:  1'b0
    };

endpackage : imm_pkg
`default_nettype wire

// File: rtl/imm_extender.sv
`default_nettype none
// ============================================================================
//  Module      : imm_extender
//  Description : Shared combinational immediate extender (RV32 I/S/B/J/U).
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_extender
    import imm_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_type_t   imm_type,
    output logic [31:0] imm
);

    always_comb begin
        imm = 32'h0;
        case (imm_type)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
            IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
            IMM_U: imm = {instr[31:12], 12'h000};
            default: imm = 32'h0;
        endcase
    end

endmodule : imm_extender
`default_nettype wire

// File: rtl/imm_opcode_decode.sv
`default_nettype none
// ============================================================================
//  Module      : imm_opcode_decode
//  Description : Combinational opcode classifier -> immediate format + illegal.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_opcode_decode
    import imm_pkg::*;
(
    input  logic [6:0] opcode,
    output imm_type_t  imm_type,
    output logic       illegal
);

    always_comb begin
        imm_type = IMM_NONE;
        illegal  = 1'b0;
        case (opcode)
            OP_IMM, LOAD, JALR: imm_type = IMM_I;
            STORE:              imm_type = IMM_S;
            BRANCH:             imm_type = IMM_B;
            JAL:                imm_type = IMM_J;
            LUI, AUIPC:         imm_type = IMM_U;
            OP, SYSTEM:         imm_type = IMM_NONE;
            default:            illegal  = 1'b1;
        endcase
    end

endmodule : imm_opcode_decode
`default_nettype wire

// File: rtl/imm_decode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : imm_decode_ctrl
//  Description : ID-stage immediate sequencer with a 2-entry (main + skid)
//                elastic buffer, pipeline flush and saturating stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_decode_ctrl
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_instr,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_imm_type,
    output logic             out_illegal,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_in_ready;
    entry_t           r_main;
    entry_t           r_skid;
    entry_t           w_new;
    logic [CNT_W-1:0] r_stall_cnt;

    imm_type_t        w_imm_type;
    logic             w_illegal;
    logic [31:0]      w_imm;

    logic             w_accept;
    logic             w_pop;
    logic             w_load_main_new;
    logic             w_load_main_skid;
    logic             w_load_skid;

    imm_opcode_decode u_opcode_decode (
        .opcode   (in_instr[6:0]),
        .imm_type (w_imm_type),
        .illegal  (w_illegal)
    );

    imm_extender u_imm_extender (
        .instr    (in_instr[31:7]),
        .imm_type (w_imm_type),
        .imm      (w_imm)
    );

    assign w_new = '{
        pc:       in_pc,
        instr:    in_instr,
        imm:      w_imm,
        imm_type: w_imm_type,
        illegal:  w_illegal
    };

    assign out_valid = (r_state != ST_EMPTY);
    assign in_ready  = r_in_ready;

    // An offer during flush is never taken, even if the buffer has room.
    assign w_accept  = in_valid & r_in_ready & ~flush;
    assign w_pop     = out_valid & out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_new  = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt     = ST_ONE;
                    w_load_main_new = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_pop) begin
                    w_load_main_new = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = ST_TWO;
                    w_load_skid = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_pop) begin
                    w_state_nxt      = ST_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_TWO);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= ENTRY_RESET;
            r_skid <= ENTRY_RESET;
        end else begin
            if (w_load_main_new) begin
                r_main <= w_new;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_new;
            end else if (w_load_main_skid || flush) begin
                r_skid <= ENTRY_RESET;
            end
        end
    end

    // Counts back-pressure cycles; sticks at all-ones and survives flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + c_cnt_one;
        end
    end

    assign out_instr    = r_main.instr;
    assign out_pc       = r_main.pc;
    assign out_imm      = r_main.imm;
    assign out_imm_type = r_main.imm_type;
    assign out_illegal  = r_main.illegal;
    assign stall_cnt    = r_stall_cnt;

endmodule : imm_decode_ctrl
`default_nettype wire
